// File: rtl/conv_layer_sequencer_if.sv
// conv_layer_sequencer_if -- control bundle between the layer sequencer and
// its environment (start/stall in, address-generator / MAC controls out).
//   start, stall           : requests into the sequencer
//   agen_rst, agen_en      : address-generator reset pulse and beat enable
//   mac_valid, acc_clr,
//   acc_last               : MAC-side beat qualifiers (pipeline aligned)
//   busy, done             : status
//   stall_cnt              : RUN-cycle stall counter (CONV_SEQ_PERF_EN only)
// Optional feature macro: CONV_SEQ_PERF_EN
// Modports: master = sequencer side, slave = environment side.
interface conv_layer_sequencer_if #(
  parameter int CNT_W = 20
);
  logic start;
  logic stall;
  logic agen_rst;
  logic agen_en;
  logic mac_valid;
  logic acc_clr;
  logic acc_last;
  logic busy;
  logic done;

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

`ifdef CONV_SEQ_PERF_EN
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  start, stall,
    output agen_rst, agen_en, mac_valid, acc_clr, acc_last, busy, done,
           stall_cnt
  );
  modport slave (
    output start, stall,
    input  agen_rst, agen_en, mac_valid, acc_clr, acc_last, busy, done,
           stall_cnt
  );
`else
  modport master (
    input  start, stall,
    output agen_rst, agen_en, mac_valid, acc_clr, acc_last, busy, done
  );
  modport slave (
    output start, stall,
    input  agen_rst, agen_en, mac_valid, acc_clr, acc_last, busy, done
  );
`endif
endinterface

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer -- sequences one convolution layer run: resets the
// address generator, issues BEATS_PER_ACC*NUM_ACC beats (held off by stall),
// drains the PIPE_LAT-deep operand pipeline, then pulses done.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : conv_layer_sequencer_if.master (start/stall in; agen_rst,
//           agen_en, mac_valid, acc_clr, acc_last, busy, done out;
//           stall_cnt out when CONV_SEQ_PERF_EN is defined)
// Optional feature macro: CONV_SEQ_PERF_EN (RUN-cycle stall counter).
module conv_layer_sequencer #(
  parameter int BEATS_PER_ACC = 9,
  parameter int NUM_ACC       = 4,
  parameter int PIPE_LAT      = 4,
  parameter int CNT_W         = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  conv_layer_sequencer_if.master bus
);
  localparam int BW = (BEATS_PER_ACC > 1) ? $clog2(BEATS_PER_ACC) : 1;
  localparam int AW = (NUM_ACC > 1)       ? $clog2(NUM_ACC)       : 1;
  localparam int DW = (PIPE_LAT > 1)      ? $clog2(PIPE_LAT)      : 1;

  if (PIPE_LAT < 1 || PIPE_LAT > 16) begin : g_bad_lat
    $error("PIPE_LAT must be in 1..16");
  end
  if (BEATS_PER_ACC < 1 || NUM_ACC < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("BEATS_PER_ACC, NUM_ACC and CNT_W must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

  // One pipeline slot per cycle: {valid, first, last}
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } pipe_t;

  state_t        r_state, w_next;
  logic [BW-1:0] r_beat;
  logic [AW-1:0] r_acc;
  logic [DW-1:0] r_drain;
  pipe_t         r_pipe [PIPE_LAT];
  pipe_t         w_in;
  logic          w_agen_rst, w_agen_en, w_busy, w_done;
  logic          w_beat_last, w_acc_last;

  assign w_beat_last = (r_beat == BW'(BEATS_PER_ACC - 1));
  assign w_acc_last  = (r_acc  == AW'(NUM_ACC - 1));

  always_comb begin
    w_next     = r_state;
    w_agen_rst = 1'b0;
    w_agen_en  = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_INIT;
      end
      S_INIT: begin
        w_agen_rst = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN: begin
        w_agen_en = !bus.stall;
        if (w_agen_en && w_beat_last && w_acc_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain == DW'(PIPE_LAT - 1)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bubbles (agen_en=0) enter the pipe as all-zero slots.
  assign w_in = '{valid: w_agen_en,
                  first: w_agen_en && (r_beat == '0),
                  last:  w_agen_en && w_beat_last};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_beat  <= '0;
      r_acc   <= '0;
      r_drain <= '0;
      for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_state   <= w_next;
      r_pipe[0] <= w_in;
      for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      if (r_state == S_INIT) begin
        r_beat <= '0;
        r_acc  <= '0;
      end else if (w_agen_en) begin
        if (w_beat_last) begin
          r_beat <= '0;
          // wraps on the final issue so the counter never exceeds NUM_ACC-1
          r_acc  <= w_acc_last ? '0 : r_acc + 1'b1;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      // counts 0..PIPE_LAT-1 while draining, cleared otherwise
      r_drain <= (r_state == S_DRAIN && w_next == S_DRAIN) ? r_drain + 1'b1 : '0;
    end
  end

  assign bus.agen_rst  = w_agen_rst;
  assign bus.agen_en   = w_agen_en;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.mac_valid = r_pipe[PIPE_LAT-1].valid;
  assign bus.acc_clr   = r_pipe[PIPE_LAT-1].first;
  assign bus.acc_last  = r_pipe[PIPE_LAT-1].last;

`ifdef CONV_SEQ_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating; holds its value after DONE until the next INIT.
  always_ff @(posedge clk) begin
    if (reset)                    r_stall_cnt <= '0;
    else if (r_state == S_INIT)   r_stall_cnt <= '0;
    else if (r_state == S_RUN && bus.stall && r_stall_cnt != '1)
                                  r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
module tb_conv_layer_sequencer;
  localparam int WMAX = 160;
  localparam int RST = 6, EN = 5, MV = 4, CLR = 3, LST = 2, BSY = 1, DN = 0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_layer_sequencer_if #(.CNT_W(20)) ifa ();
  conv_layer_sequencer_if #(.CNT_W(8))  ifb ();

  conv_layer_sequencer #(.BEATS_PER_ACC(9), .NUM_ACC(4), .PIPE_LAT(4), .CNT_W(20))
    u_a (.clk(clk), .reset(reset), .bus(ifa));
  conv_layer_sequencer #(.BEATS_PER_ACC(1), .NUM_ACC(3), .PIPE_LAT(1), .CNT_W(8))
    u_b (.clk(clk), .reset(reset), .bus(ifb));

  // Stimulus and traces for a window; index k = rising edge number in window.
  logic       st_start [WMAX];
  logic       st_stall [WMAX];
  logic [6:0] obs_v [2][WMAX];
  int         obs_sc [2][WMAX];
  logic [6:0] ev [2][WMAX];
  int         esc [2][WMAX];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] vec_a();
    return {ifa.agen_rst, ifa.agen_en, ifa.mac_valid, ifa.acc_clr, ifa.acc_last, ifa.busy, ifa.done};
  endfunction
  function automatic logic [6:0] vec_b();
    return {ifb.agen_rst, ifb.agen_en, ifb.mac_valid, ifb.acc_clr, ifb.acc_last, ifb.busy, ifb.done};
  endfunction
  function automatic int sc_a();
`ifdef CONV_SEQ_PERF_EN
    return int'(ifa.stall_cnt);
`else
    return 0;
`endif
  endfunction
  function automatic int sc_b();
`ifdef CONV_SEQ_PERF_EN
    return int'(ifb.stall_cnt);
`else
    return 0;
`endif
  endfunction

  function automatic void setb(input int d, input int idx, input int b);
    if (idx >= 0 && idx < WMAX) ev[d][idx][b] = 1'b1;
  endfunction

  // Run-level reference: each accepted start yields INIT, then B*N issue
  // cycles (skipping stalled cycles), P drain cycles and one done cycle.
  // The MAC side sees the issue stream P cycles later.
  task automatic model(input int d, input int B, input int N, input int P, input int T);
    int k, s, kk, issued, stalls, last_iss;
    for (int i = 0; i < WMAX; i++) begin ev[d][i] = '0; esc[d][i] = 0; end
    k = 0;
    while (k < T) begin
      if (!st_start[k]) begin k++; continue; end
      s = k; issued = 0; stalls = 0; kk = s + 2; last_iss = s + 1;
      setb(d, s + 1, RST); setb(d, s + 1, BSY);
      while (issued < B * N && kk < WMAX) begin
        setb(d, kk, BSY);
        esc[d][kk] = stalls;
        if (!st_stall[kk]) begin
          setb(d, kk, EN);
          setb(d, kk + P, MV);
          if (issued % B == 0)     setb(d, kk + P, CLR);
          if (issued % B == B - 1) setb(d, kk + P, LST);
          issued++;
          last_iss = kk;
        end else begin
          stalls++;
        end
        kk++;
      end
      for (int j = last_iss + 1; j < WMAX; j++) esc[d][j] = stalls;
      for (int j = 1; j <= P; j++) setb(d, last_iss + j, BSY);
      setb(d, last_iss + P + 1, BSY);
      setb(d, last_iss + P + 1, DN);
      k = last_iss + P + 2;
    end
  endtask

  task automatic drive(input logic s, input logic st);
    ifa.start = s; ifb.start = s;
    ifa.stall = st; ifb.stall = st;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; drive(1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < WMAX; i++) begin st_start[i] = 1'b0; st_stall[i] = 1'b0; end
  endtask

  task automatic run_window(input int wid, input int T);
    do_reset();
    for (int k = 0; k < T; k++) begin
      @(negedge clk);
      drive(st_start[k], st_stall[k]);
      #1;
      obs_v[0][k] = vec_a(); obs_v[1][k] = vec_b();
      obs_sc[0][k] = sc_a(); obs_sc[1][k] = sc_b();
    end
    drive(1'b0, 1'b0);
    model(0, 9, 4, 4, T);
    model(1, 1, 3, 1, T);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < T; k++) begin
        chk($sformatf("w%0d dut%0d edge%0d outs", wid, d, k), 32'(obs_v[d][k]), 32'(ev[d][k]));
`ifdef CONV_SEQ_PERF_EN
        chk($sformatf("w%0d dut%0d edge%0d stall_cnt", wid, d, k), obs_sc[d][k], esc[d][k]);
`endif
      end
  endtask

  function automatic int first_idx(input int d, input int b, input int T);
    for (int k = 0; k < T; k++) if (obs_v[d][k][b]) return k;
    return -1;
  endfunction
  function automatic int last_idx(input int d, input int b, input int T);
    for (int k = T - 1; k >= 0; k--) if (obs_v[d][k][b]) return k;
    return -1;
  endfunction
  function automatic int count_bit(input int d, input int b, input int T);
    int n = 0;
    for (int k = 0; k < T; k++) if (obs_v[d][k][b]) n++;
    return n;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b1);
    // Reset state, with start/stall held high while reset is asserted
    repeat (2) @(negedge clk);
    #1;
    chk("reset outs a", 32'(vec_a()), 32'd0);
    chk("reset outs b", 32'(vec_b()), 32'd0);
    chk("reset stall_cnt a", sc_a(), 0);
    reset = 1'b0;
    drive(1'b0, 1'b0);

    // A: single start at edge 0, no stall
    clear_stim();
    st_start[0] = 1'b1;
    run_window(0, 50);
    chk("A agen_rst edge", first_idx(0, RST, 50), 1);
    chk("A first agen_en", first_idx(0, EN, 50), 2);
    chk("A last agen_en",  last_idx(0, EN, 50), 37);
    chk("A first mac_valid", first_idx(0, MV, 50), 6);
    chk("A last mac_valid",  last_idx(0, MV, 50), 41);
    chk("A done edge", first_idx(0, DN, 50), 42);
    chk("A acc_clr count",  count_bit(0, CLR, 50), 4);
    chk("A acc_last count", count_bit(0, LST, 50), 4);
    chk("A first acc_clr",  first_idx(0, CLR, 50), 6);
    chk("B mac_valid count", count_bit(1, MV, 50), 3);
    chk("B acc_clr count",   count_bit(1, CLR, 50), 3);
    chk("B acc_last count",  count_bit(1, LST, 50), 3);

    // B: three stalled cycles mid-RUN, plus stall during INIT and DRAIN
    clear_stim();
    st_start[0] = 1'b1;
    st_stall[1] = 1'b1;
    for (int k = 15; k < 18; k++) st_stall[k] = 1'b1;
    st_stall[42] = 1'b1;
    run_window(1, 55);
    chk("stall done edge", first_idx(0, DN, 55), 45);
    chk("stall agen_en count", count_bit(0, EN, 55), 36);
`ifdef CONV_SEQ_PERF_EN
    chk("stall_cnt held", obs_sc[0][54], 3);
`endif

    // C: random stall everywhere, stray starts while busy
    clear_stim();
    st_start[0] = 1'b1;
    st_start[20 + $urandom_range(0, 9)] = 1'b1;
    st_start[40 + $urandom_range(0, 9)] = 1'b1;
    for (int k = 0; k < 120; k++) st_stall[k] = ($urandom_range(0, 3) == 0);
    run_window(2, 120);
    chk("rand acc_clr count a", count_bit(0, CLR, 120), 4);

    // D: start held high throughout
    clear_stim();
    for (int k = 0; k < 130; k++) st_start[k] = 1'b1;
    for (int k = 0; k < 130; k++) st_stall[k] = ($urandom_range(0, 7) == 0);
    run_window(3, 130);

    // E: reset while beat 20 is issued
    do_reset();
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      drive(k == 0, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("mid agen_en before reset", 32'(ifa.agen_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid reset outs a", 32'(vec_a()), 32'd0);
    chk("mid reset stall_cnt", sc_a(), 0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-abort edge%0d outs a", k), 32'(vec_a()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameter BEATS_PER_ACC, default 9: address-generator beats per output accumulation (K*K*input maps per memory).
REQ-002 Parameter NUM_ACC, default 4: accumulations per layer run.
REQ-003 Parameter PIPE_LAT, default 4: cycles from agen_en to the matching operand at the MAC input; range 1..16.
REQ-004 Parameter CNT_W, default 20: width of the stall counter.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  layer start request; sampled only in IDLE.
REQ-008 stall  in  1  downstream back-pressure; suppresses issue while high.
REQ-009 agen_rst  out  1  one-cycle reset pulse to the address generator.
REQ-010 agen_en  out  1  address-generator enable; one beat per high cycle.
REQ-011 mac_valid  out  1  agen_en delayed by PIPE_LAT cycles.
REQ-012 acc_clr  out  1  first beat of an accumulation, aligned with mac_valid.
REQ-013 acc_last  out  1  last beat of an accumulation, aligned with mac_valid.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 stall_cnt  out  CNT_W  RUN cycles with stall=1; present only when CONV_SEQ_PERF_EN is defined.

Function
REQ-017 The FSM SHALL have five states: IDLE, INIT, RUN, DRAIN, DONE, encoded in registers.
REQ-018 IDLE -> INIT when start=1; otherwise stay in IDLE; start outside IDLE SHALL be ignored.
REQ-019 INIT SHALL last one cycle with agen_rst=1, clear beat/acc counters, then go to RUN.
REQ-020 In RUN: agen_en = !stall (combinational from registered state); the beat counter increments on each agen_en cycle and wraps at BEATS_PER_ACC-1, at which point the acc counter increments.
REQ-021 The issue cycle where agen_en=1, beat=BEATS_PER_ACC-1 and acc=NUM_ACC-1 SHALL move RUN -> DRAIN; exactly BEATS_PER_ACC*NUM_ACC beats issue per run.
REQ-022 DRAIN SHALL last exactly PIPE_LAT cycles with agen_en=0, then go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE; a start in DONE is ignored.
REQ-024 A PIPE_LAT-deep shift register SHALL carry {valid, first, last} per cycle; it shifts every cycle regardless of stall; bubbles shift in as zeros.
REQ-025 first=1 when beat=0 at issue; last=1 when beat=BEATS_PER_ACC-1 at issue; with BEATS_PER_ACC=1 both are set on the same beat.
REQ-026 The counter widths SHALL be clog2 of their limits (minimum 1 bit); the counters never exceed their limits.
REQ-027 stall during INIT, DRAIN or DONE SHALL have no effect.

Reset
REQ-028 On reset=1 at a clock edge: state=IDLE, counters=0, shift register=0, all outputs 0, stall_cnt=0.
REQ-029 Reset in any state, including mid-RUN, SHALL abort the run with no done pulse; a new start is required.

Configuration
REQ-030 When CONV_SEQ_PERF_EN is defined, stall_cnt SHALL exist, clear in INIT, increment saturating on each RUN cycle with stall=1, and hold its value after DONE until the next INIT.
REQ-031 When CONV_SEQ_PERF_EN is undefined, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Defaults, one-cycle start at edge 0, stall=0 -> agen_rst at edge 1; agen_en high for 36 cycles (edges 2..37); mac_valid for edges 6..41; done at edge 42.
REQ-033 Defaults, stall=1 for 3 cycles mid-RUN -> agen_en low for those 3 cycles; done at edge 45; stall_cnt=3 (with macro).
REQ-034 Defaults, no stall -> acc_clr pulses 4 times and acc_last pulses 4 times, each 9 mac_valid cycles apart; the first acc_clr coincides with the first mac_valid.
REQ-035 start held high through busy -> a single run; the next run begins only after IDLE is re-entered.
REQ-036 reset asserted at beat 20 -> next cycle all outputs 0 and state IDLE; no done pulse; mac_valid stays 0.
REQ-037 BEATS_PER_ACC=1, NUM_ACC=3, PIPE_LAT=1 -> 3 mac_valid cycles, each with acc_clr=acc_last=1.
